// File: rtl/debug_pkg.sv
// Types and constants shared by the commit monitor and its watchdog.
package debug_pkg;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_EBREAK  = 2'd1,
    HALT_TIMEOUT = 2'd2
  } halt_cause_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } mon_state_t;

  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam logic [31:0] WATCHDOG_DEFAULT = 32'd1_000_000;

endpackage

// File: rtl/commit_monitor_if.sv
// Writeback-in / debug-out bundle of the commit monitor.
interface commit_monitor_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_regWen;
  logic [4:0]  wb_regWaddr;
  logic [31:0] wb_regWdata;

  logic        debug_valid;
  logic        debug_halt;
  logic [31:0] debug_pc;
  logic        debug_regWen;
  logic [4:0]  debug_regWaddr;
  logic [31:0] debug_regWdata;

  // master: CPU writeback + debug sink side
  modport master (
    output wb_valid, wb_pc, wb_inst, wb_regWen, wb_regWaddr, wb_regWdata,
    input  debug_valid, debug_halt, debug_pc, debug_regWen, debug_regWaddr, debug_regWdata
  );

  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_regWen, wb_regWaddr, wb_regWdata,
    output debug_valid, debug_halt, debug_pc, debug_regWen, debug_regWaddr, debug_regWdata
  );
endinterface

// File: rtl/commit_watchdog.sv
// No-commit watchdog: pulses expired on the WATCHDOG_CYCLES-th consecutive idle cycle.
module commit_watchdog
  import debug_pkg::*;
#(
  parameter logic [31:0] WATCHDOG_CYCLES = WATCHDOG_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  logic [31:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (kick)                        r_cnt <= '0;
      else if (r_cnt < WATCHDOG_CYCLES) r_cnt <= r_cnt + 32'd1;
    end
  end

  // Combinational so the top registers the timeout on the same edge the count reaches the limit.
  assign expired = enable && !kick && (WATCHDOG_CYCLES != 32'd0) &&
                   (r_cnt == WATCHDOG_CYCLES - 32'd1);

endmodule

// File: rtl/commit_monitor.sv
// Registers retired instructions onto the debug port and raises exactly one halt event per run.
module commit_monitor
  import debug_pkg::*;
#(
  parameter logic [31:0] WATCHDOG_CYCLES = WATCHDOG_DEFAULT,
  parameter logic [31:0] EBREAK_INST     = debug_pkg::EBREAK_INST
) (
  input  logic                  clock,
  input  logic                  reset,
  commit_monitor_if.slave       bus,
  output logic [63:0]           commit_count,
  output logic [1:0]            halt_cause
);

  mon_state_t  r_state, w_state_nxt;
  halt_cause_t r_cause, w_cause;
  logic        r_valid, r_halt, r_wen;
  logic [31:0] r_pc, r_wdata, r_last_pc;
  logic [4:0]  r_waddr;
  logic [63:0] r_count;

  logic        w_valid, w_halt, w_wen, w_expired, w_enable;
  logic [31:0] w_pc, w_wdata, w_last_pc;
  logic [4:0]  w_waddr;
  logic [63:0] w_count;

  assign w_enable = (r_state == ST_RUN);

  commit_watchdog #(.WATCHDOG_CYCLES(WATCHDOG_CYCLES)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .enable  (w_enable),
    .kick    (bus.wb_valid),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_halt      = 1'b0;
    w_pc        = r_pc;
    w_wen       = 1'b0;
    w_waddr     = r_waddr;
    w_wdata     = r_wdata;
    w_count     = r_count;
    w_cause     = r_cause;
    w_last_pc   = r_last_pc;
    if (r_state == ST_RUN) begin
      // A commit always beats a coincident watchdog expiry.
      if (bus.wb_valid) begin
        w_valid   = 1'b1;
        w_pc      = bus.wb_pc;
        w_wen     = bus.wb_regWen && (bus.wb_regWaddr != 5'd0);
        w_waddr   = bus.wb_regWaddr;
        w_wdata   = bus.wb_regWdata;
        w_count   = r_count + 64'd1;
        w_last_pc = bus.wb_pc;
        if (bus.wb_inst == EBREAK_INST) begin
          w_halt      = 1'b1;
          w_cause     = HALT_EBREAK;
          w_state_nxt = ST_HALTED;
        end
      end else if (w_expired) begin
        w_valid     = 1'b1;
        w_halt      = 1'b1;
        w_pc        = r_last_pc;
        w_waddr     = 5'd0;
        w_wdata     = 32'd0;
        w_cause     = HALT_TIMEOUT;
        w_state_nxt = ST_HALTED;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_halt    <= 1'b0;
      r_pc      <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_count   <= '0;
      r_cause   <= HALT_NONE;
      r_last_pc <= '0;
    end else begin
      r_valid   <= w_valid;
      r_halt    <= w_halt;
      r_pc      <= w_pc;
      r_wen     <= w_wen;
      r_waddr   <= w_waddr;
      r_wdata   <= w_wdata;
      r_count   <= w_count;
      r_cause   <= w_cause;
      r_last_pc <= w_last_pc;
    end
  end

  assign bus.debug_valid    = r_valid;
  assign bus.debug_halt     = r_halt;
  assign bus.debug_pc       = r_pc;
  assign bus.debug_regWen   = r_wen;
  assign bus.debug_regWaddr = r_waddr;
  assign bus.debug_regWdata = r_wdata;
  assign commit_count       = r_count;
  assign halt_cause         = r_cause;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: vector table, hand sequences and random stimulus vs. a reference model.
module tb_commit_monitor;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [63:0] cnt8, cnt0;
  logic [1:0]  cause8, cause0;

  int checks = 0;
  int errors = 0;

  commit_monitor_if bus8 ();
  commit_monitor_if bus0 ();

  commit_monitor #(.WATCHDOG_CYCLES(32'd8)) dut (
    .clock(clock), .reset(reset), .bus(bus8), .commit_count(cnt8), .halt_cause(cause8)
  );
  commit_monitor #(.WATCHDOG_CYCLES(32'd0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .commit_count(cnt0), .halt_cause(cause0)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] pc, inst;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_v, e_h;
    logic [31:0] e_pc;
    logic        e_wen;
    logic [63:0] e_cnt;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t tbl[8];

  // reference model, index 0 -> WATCHDOG_CYCLES=8, index 1 -> 0
  int unsigned m_w[2] = '{8, 0};
  bit          m_halted[2];
  int          m_idle[2];
  logic [63:0] m_cnt[2];
  logic [1:0]  m_cause[2];
  logic [31:0] m_last[2];
  logic        e_v[2], e_h[2], e_wen[2];
  logic [31:0] e_pc[2], e_wd[2];
  logic [4:0]  e_wa[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    bus8.wb_valid = v;  bus8.wb_pc = pc;  bus8.wb_inst = inst;
    bus8.wb_regWen = wen; bus8.wb_regWaddr = wa; bus8.wb_regWdata = wd;
    bus0.wb_valid = v;  bus0.wb_pc = pc;  bus0.wb_inst = inst;
    bus0.wb_regWen = wen; bus0.wb_regWaddr = wa; bus0.wb_regWdata = wd;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_halted[m] = 0; m_idle[m] = 0; m_cnt[m] = '0; m_cause[m] = 2'd0; m_last[m] = '0;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic model_step(input int m, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    e_v[m] = 1'b0; e_h[m] = 1'b0; e_wen[m] = 1'b0; e_pc[m] = '0; e_wa[m] = '0; e_wd[m] = '0;
    if (!m_halted[m]) begin
      if (v) begin
        e_v[m] = 1'b1; e_pc[m] = pc; e_wen[m] = wen && (wa != 0); e_wa[m] = wa; e_wd[m] = wd;
        m_cnt[m] = m_cnt[m] + 1; m_last[m] = pc; m_idle[m] = 0;
        if (inst == EBRK) begin
          e_h[m] = 1'b1; m_halted[m] = 1; m_cause[m] = 2'd1;
        end
      end else begin
        m_idle[m]++;
        if (m_w[m] != 0 && m_idle[m] == int'(m_w[m])) begin
          e_v[m] = 1'b1; e_h[m] = 1'b1; e_pc[m] = m_last[m];
          m_halted[m] = 1; m_cause[m] = 2'd2;
        end
      end
    end
  endtask

  task automatic cmp(input int m, input logic av, input logic ah, input logic [31:0] apc,
                     input logic aw, input logic [4:0] awa, input logic [31:0] awd,
                     input logic [63:0] acnt, input logic [1:0] acause);
    chk($sformatf("rnd%0d valid", m), 64'(av), 64'(e_v[m]));
    chk($sformatf("rnd%0d halt", m), 64'(ah), 64'(e_h[m]));
    chk($sformatf("rnd%0d count", m), acnt, m_cnt[m]);
    chk($sformatf("rnd%0d cause", m), 64'(acause), 64'(m_cause[m]));
    if (e_v[m]) begin
      chk($sformatf("rnd%0d pc", m), 64'(apc), 64'(e_pc[m]));
      chk($sformatf("rnd%0d regWen", m), 64'(aw), 64'(e_wen[m]));
      if (!e_h[m]) begin
        chk($sformatf("rnd%0d waddr", m), 64'(awa), 64'(e_wa[m]));
        chk($sformatf("rnd%0d wdata", m), 64'(awd), 64'(e_wd[m]));
      end
    end
  endtask

  // waits for a debug_valid on dut; returns number of edges taken, 99 if none within bound
  task automatic wait_pulse(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus8.debug_valid) begin n = i; break; end
    end
  endtask

  initial begin
    int n, seen, dens;
    logic        rv, rw;
    logic [31:0] rpc, rinst, rwd;
    logic [4:0]  rwa;

    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #3;
    chk("reset valid", 64'(bus8.debug_valid), 64'd0);
    chk("reset halt", 64'(bus8.debug_halt), 64'd0);
    chk("reset pc", 64'(bus8.debug_pc), 64'd0);
    chk("reset count", cnt8, 64'd0);
    chk("reset cause", 64'(cause8), 64'd0);
    chk("reset0 valid", 64'(bus0.debug_valid), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // table: back-to-back commits, x0 write, ebreak, ignored commit while halted
    tbl[0] = '{1'b1, 32'h8000_0000, NOP,  1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 64'd1, 2'd0};
    tbl[1] = '{1'b1, 32'h8000_0004, NOP,  1'b1, 5'd0, 32'hFFFF, 1'b1, 1'b0, 32'h8000_0004, 1'b0, 64'd2, 2'd0};
    tbl[2] = '{1'b0, 32'h0,         NOP,  1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b0, 64'd2, 2'd0};
    tbl[3] = '{1'b1, 32'h8000_0010, EBRK, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h8000_0010, 1'b0, 64'd3, 2'd1};
    tbl[4] = '{1'b0, 32'h0,         NOP,  1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b0, 64'd3, 2'd1};
    tbl[5] = '{1'b0, 32'h0,         NOP,  1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b0, 64'd3, 2'd1};
    tbl[6] = '{1'b1, 32'h8000_0014, NOP,  1'b1, 5'd3, 32'h77,   1'b0, 1'b0, 32'h0,         1'b0, 64'd3, 2'd1};
    tbl[7] = '{1'b0, 32'h0,         NOP,  1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 32'h0,         1'b0, 64'd3, 2'd1};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].wen, tbl[i].wa, tbl[i].wd);
      step();
      chk($sformatf("tbl%0d valid", i), 64'(bus8.debug_valid), 64'(tbl[i].e_v));
      chk($sformatf("tbl%0d halt", i), 64'(bus8.debug_halt), 64'(tbl[i].e_h));
      chk($sformatf("tbl%0d count", i), cnt8, tbl[i].e_cnt);
      chk($sformatf("tbl%0d cause", i), 64'(cause8), 64'(tbl[i].e_cause));
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d pc", i), 64'(bus8.debug_pc), 64'(tbl[i].e_pc));
        chk($sformatf("tbl%0d regWen", i), 64'(bus8.debug_regWen), 64'(tbl[i].e_wen));
        if (!tbl[i].e_h) begin
          chk($sformatf("tbl%0d waddr", i), 64'(bus8.debug_regWaddr), 64'(tbl[i].wa));
          chk($sformatf("tbl%0d wdata", i), 64'(bus8.debug_regWdata), 64'(tbl[i].wd));
        end
      end
    end

    // timeout after a single commit
    do_reset();
    drive(1'b1, 32'h8000_0020, NOP, 1'b1, 5'd1, 32'h7);
    step();
    chk("to commit valid", 64'(bus8.debug_valid), 64'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    wait_pulse(n);
    chk("to latency", 64'(n), 64'd8);
    chk("to halt", 64'(bus8.debug_halt), 64'd1);
    chk("to pc", 64'(bus8.debug_pc), 64'h8000_0020);
    chk("to regWen", 64'(bus8.debug_regWen), 64'd0);
    chk("to cause", 64'(cause8), 64'd2);
    chk("to count", cnt8, 64'd1);
    step();
    chk("to single pulse", 64'(bus8.debug_valid), 64'd0);

    // commit coincident with expiry restarts the watchdog
    do_reset();
    drive(1'b1, 32'h8000_0030, NOP, 1'b0, 5'd0, 32'h0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    seen = 0;
    for (int i = 0; i < 7; i++) begin step(); if (bus8.debug_valid) seen++; end
    chk("co idle no event", 64'(seen), 64'd0);
    drive(1'b1, 32'h8000_0034, NOP, 1'b1, 5'd9, 32'hABCD);
    step();
    chk("co valid", 64'(bus8.debug_valid), 64'd1);
    chk("co halt", 64'(bus8.debug_halt), 64'd0);
    chk("co pc", 64'(bus8.debug_pc), 64'h8000_0034);
    chk("co cause", 64'(cause8), 64'd0);
    chk("co count", cnt8, 64'd2);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    wait_pulse(n);
    chk("co restart latency", 64'(n), 64'd8);
    chk("co restart pc", 64'(bus8.debug_pc), 64'h8000_0034);
    chk("co restart cause", 64'(cause8), 64'd2);

    // asynchronous reset mid-cycle right after the halt event
    do_reset();
    drive(1'b1, 32'h8000_0040, EBRK, 1'b0, 5'd0, 32'h0);
    step();
    chk("ar halt pulse", 64'(bus8.debug_halt), 64'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar valid", 64'(bus8.debug_valid), 64'd0);
    chk("ar halt", 64'(bus8.debug_halt), 64'd0);
    chk("ar pc", 64'(bus8.debug_pc), 64'd0);
    chk("ar count", cnt8, 64'd0);
    chk("ar cause", 64'(cause8), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 32'h0000_0100, NOP, 1'b1, 5'd2, 32'h55);
    step();
    chk("ar post valid", 64'(bus8.debug_valid), 64'd1);
    chk("ar post pc", 64'(bus8.debug_pc), 64'h100);
    chk("ar post count", cnt8, 64'd1);
    chk("ar post cause", 64'(cause8), 64'd0);

    // random stimulus against the model, both watchdog settings
    do_reset();
    dens = 70;
    for (int c = 0; c < 2000; c++) begin
      if (c % 150 == 149) do_reset();
      if (c % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: dens = 80;
          1: dens = 25;
          default: dens = 4;
        endcase
      end
      rv    = ($urandom_range(0, 99) < dens);
      rpc   = $urandom;
      rinst = ($urandom_range(0, 31) == 0) ? EBRK : $urandom;
      rw    = 1'($urandom_range(0, 1));
      rwa   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      rwd   = $urandom;
      drive(rv, rpc, rinst, rw, rwa, rwd);
      model_step(0, rv, rpc, rinst, rw, rwa, rwd);
      model_step(1, rv, rpc, rinst, rw, rwa, rwd);
      step();
      cmp(0, bus8.debug_valid, bus8.debug_halt, bus8.debug_pc, bus8.debug_regWen,
          bus8.debug_regWaddr, bus8.debug_regWdata, cnt8, cause8);
      cmp(1, bus0.debug_valid, bus0.debug_halt, bus0.debug_pc, bus0.debug_regWen,
          bus0.debug_regWaddr, bus0.debug_regWdata, cnt0, cause0);
    end

    // watchdog disabled: long idle stretch never halts
    do_reset();
    seen = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (bus0.debug_valid) seen++;
    end
    chk("wd0 no events", 64'(seen), 64'd0);
    chk("wd0 cause", 64'(cause0), 64'd0);
    chk("wd0 count", cnt0, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Retirement-side front end of the simulation debug port. Sits between the CPU writeback stage and the debug sink that consumes `debug_valid`/`debug_halt`/`debug_pc`/`debug_reg*`. It registers each retired instruction onto the debug port and detects `ebreak`. It runs a no-commit watchdog, counts retired instructions, and latches a single halt event so the sink sees exactly one halt pulse per run.

## Interface
Parameters:
- `WATCHDOG_CYCLES`, 32'd1_000_000: idle cycles without a commit before a timeout halt; 0 disables the watchdog.
- `EBREAK_INST`, 32'h0010_0073: instruction encoding treated as a halt trap.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `wb_valid`  in  1  one instruction retires this cycle.
- `wb_pc`  in  32  PC of the retiring instruction.
- `wb_inst`  in  32  encoding of the retiring instruction.
- `wb_regWen`  in  1  retiring instruction writes a GPR.
- `wb_regWaddr`  in  5  destination GPR.
- `wb_regWdata`  in  32  value written.
- `debug_valid`  out  1  registered commit/halt event.
- `debug_halt`  out  1  event is the halt event.
- `debug_pc`  out  32  PC of the event.
- `debug_regWen`  out  1  GPR write, forced 0 for x0.
- `debug_regWaddr`  out  5  destination GPR.
- `debug_regWdata`  out  32  value written.
- `commit_count`  out  64  number of retired instructions forwarded, including the ebreak.
- `halt_cause`  out  2  0 none, 1 ebreak, 2 timeout; sticky.

## Operation
- FSM states: RUN, HALTED.
- RUN, `wb_valid`=1:
  - Next cycle, `debug_valid`=1 and `debug_pc/regWaddr/regWdata` equal the wb inputs.
  - `debug_regWen` = `wb_regWen && wb_regWaddr!=0`.
  - `commit_count` increments by 1.
  - The watchdog counter clears to 0.
  - The last committed PC is stored.
- RUN, `wb_valid`=1 with `wb_inst==EBREAK_INST`:
  - Same commit as above, plus `debug_halt`=1 and `halt_cause`=1.
  - FSM goes to HALTED.
- RUN, `wb_valid`=0: watchdog increments, saturating.
- Watchdog reaches `WATCHDOG_CYCLES` with no commit:
  - One output event: `debug_valid`=1, `debug_halt`=1, `debug_pc`=last committed PC (0 if none), `debug_regWen`=0.
  - `halt_cause`=2; FSM goes to HALTED.
  - `commit_count` unchanged.
- HALTED:
  - `wb_valid` is ignored; `debug_valid`=0 every cycle.
  - Counters frozen; `halt_cause` held.
  - Exit only via reset.
- Simultaneous commit and watchdog expiry in the same cycle: the commit wins and the watchdog clears.
- `WATCHDOG_CYCLES`=0: the timeout path is never taken and the counter stays 0.

## Timing
- Latency: wb inputs to debug outputs is 1 cycle; all outputs are registered.
- No backpressure; the sink accepts every `debug_valid` cycle. Back-to-back commits produce back-to-back `debug_valid`.
- `debug_valid` is a single-cycle pulse per event; `debug_halt` is high only together with `debug_valid`.
- Timeout fires on the cycle after the `WATCHDOG_CYCLES`-th consecutive idle cycle.
- Reset (any time, including mid-run or HALTED) asynchronously forces:
  - all `debug_*` = 0, `commit_count`=0, `halt_cause`=0;
  - watchdog = 0, last PC = 0, FSM = RUN.
- First commit is accepted on the first rising edge after reset deasserts.
- `commit_count` wraps at 2^64 (not reachable in practice; no saturation required).

## Structure
- Shared package `debug_pkg`:
  - `halt_cause_t` enum {HALT_NONE=2'd0, HALT_EBREAK=2'd1, HALT_TIMEOUT=2'd2};
  - constant `EBREAK_INST`;
  - FSM state typedef.
- Sub-module `commit_watchdog`:
  - inputs: `clock`, `reset`, `enable` (FSM in RUN), `kick` (`wb_valid`);
  - output: `expired` (single-cycle pulse);
  - parameterised by `WATCHDOG_CYCLES`.
- The top contains the FSM, output registers and `commit_count`.

## Test plan
- Commits at pc 0x8000_0000 (x5←0x1234) and 0x8000_0004 (x0←0xFFFF) back-to-back:
  - two consecutive `debug_valid` pulses;
  - second has `debug_regWen`=0;
  - `commit_count`=2.
- Commit `EBREAK_INST` at pc 0x8000_0010:
  - next cycle `debug_valid`=`debug_halt`=1, pc 0x8000_0010, `halt_cause`=1;
  - a further `wb_valid` 3 cycles later produces no `debug_valid`.
- `WATCHDOG_CYCLES`=8, one commit at 0x8000_0020 then idle:
  - halt pulse exactly 8 idle cycles later with pc 0x8000_0020, `halt_cause`=2;
  - `commit_count`=1.
- `WATCHDOG_CYCLES`=8, commit on idle cycle 8 (coincident with expiry):
  - no timeout; normal commit; watchdog restarts.
- Assert `reset`=0 asynchronously in HALTED, mid-cycle:
  - outputs clear immediately, before the next edge;
  - after release, a commit at 0x100 yields `commit_count`=1, `halt_cause`=0.
- `WATCHDOG_CYCLES`=0, 10,000 idle cycles: no `debug_valid`, `halt_cause` stays 0.
